// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the soc_system sysid checker.
// Golden defaults match the sysid peripheral built into the current image.
package soc_system_sysid_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdId,
        StRdTs,
        StDone
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD51302;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5733DC2A;

endpackage

// File: rtl/soc_system_sysid_wdog.sv
// Stall watchdog: counts consecutive stalled read cycles and flags the cycle
// in which the count reaches TIMEOUT_CYCLES.
module soc_system_sysid_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q;

    // Expires on the edge that would bring the count up to TIMEOUT_CYCLES.
    assign expired = enable && (count_q == LastCnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that reads the sysid ID and timestamp words and flags a match.
// Define SYSID_CHECK_TIMEOUT_EN to abort reads stalled for TIMEOUT_CYCLES cycles.
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_e state_q;
    logic   stall_expired;
    logic   data_match;

    assign data_match = (state_q == StRdId) ? (avm_readdata == EXPECTED_ID)
                                            : (avm_readdata == EXPECTED_TS);

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic stalled;

    // Any non-stalled cycle clears the count, so it restarts on every state entry.
    assign stalled = avm_read & avm_waitrequest;

    soc_system_sysid_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (~stalled),
        .enable (stalled),
        .expired(stall_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign stall_expired      = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        id_value    <= '0;
                        ts_value    <= '0;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        state_q     <= StRdId;
                    end
                end
                StRdId: begin
                    if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        id_ok       <= data_match;
                        avm_address <= SYSID_ADDR_TS;
                        state_q     <= StRdTs;
                    end else if (stall_expired) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StRdTs: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        ts_ok    <= data_match;
                        pass     <= id_ok & (data_match | ~CHECK_TS);
                        avm_read <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end else if (stall_expired) begin
                        avm_read <= 1'b0;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
